fp32_add_arbiter: RTL and testbench

FP32_ADD_ARBITER -- requirements
Module: fp32_add_arbiter

---
 rtl/fp32_add_arbiter.sv | 133 +++++++++++++
 tb/tb_fp32_add_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp32_add_arbiter.sv
// Round-robin arbiter sharing one pipelined FP32 adder among NUM_REQ requesters.
// A {valid,id} tag pipeline tracks each issue so the returning sum is routed to its owner.
module fp32_add_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ADD_LATENCY = 6
) (
  input  logic                       s_clk,
  input  logic                       s_rst_n,
  input  logic                       en,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [32*NUM_REQ-1:0]      req_data1,
  input  logic [32*NUM_REQ-1:0]      req_data2,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       add_valid,
  output logic [31:0]                add_data1,
  output logic [31:0]                add_data2,
  input  logic                       add_result_valid,
  input  logic [31:0]                add_result,
  output logic                       rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [31:0]                rsp_data,
  output logic                       busy,
  output logic                       err,
  input  logic                       err_clr
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int LAST = ADD_LATENCY - 1;

  logic [ID_W-1:0]     r_rr_ptr;
  logic                r_add_valid;
  logic [31:0]         r_add_data1;
  logic [31:0]         r_add_data2;
  logic [LAST:0]       r_tag_vld;
  logic [ID_W-1:0]     r_tag_id [ADD_LATENCY];
  logic                r_rsp_valid;
  logic [ID_W-1:0]     r_rsp_id;
  logic [31:0]         r_rsp_data;
  logic                r_err;

  logic                w_found;
  logic                w_accept;
  logic [ID_W-1:0]     w_grant_id;
  logic [NUM_REQ-1:0]  w_grant_oh;
  logic [31:0]         w_op1;
  logic [31:0]         w_op2;
  logic [ID_W-1:0]     w_ptr_nxt;
  logic                w_tag_last_vld;
  logic [ID_W-1:0]     w_tag_last_id;

  function automatic int wrap_idx(input int base, input int off);
    return (base + off) % NUM_REQ;
  endfunction

  // NOTE: every variable written here gets a default first so no path can infer a latch.
  always_comb begin
    w_found    = 1'b0;
    w_grant_id = '0;
    w_grant_oh = '0;
    w_op1      = '0;
    w_op2      = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      if (!w_found && req_valid[wrap_idx(int'(r_rr_ptr), off)]) begin
        w_found    = 1'b1;
        w_grant_id = ID_W'(wrap_idx(int'(r_rr_ptr), off));
        w_grant_oh[wrap_idx(int'(r_rr_ptr), off)] = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant_oh[i]) begin
        w_op1 = req_data1[32*i +: 32];
        w_op2 = req_data2[32*i +: 32];
      end
    end
  end

  // Grants are suppressed while reset is held so nothing is accepted into a cleared pipeline.
  assign w_accept  = w_found & en & s_rst_n;
  assign req_ready = w_accept ? w_grant_oh : '0;
  assign w_ptr_nxt = (w_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_id + 1'b1;

  assign w_tag_last_vld = r_tag_vld[LAST];
  assign w_tag_last_id  = r_tag_id[LAST];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_rr_ptr    <= '0;
      r_add_valid <= 1'b0;
      r_add_data1 <= '0;
      r_add_data2 <= '0;
      r_tag_vld   <= '0;
      // NOTE: the tag ids are a small register array, not RAM, so they can be cleared here.
      for (int i = 0; i < ADD_LATENCY; i++) r_tag_id[i] <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_add_valid <= w_accept;
      if (w_accept) begin
        r_rr_ptr    <= w_ptr_nxt;
        r_add_data1 <= w_op1;
        r_add_data2 <= w_op2;
      end

      r_tag_vld   <= {r_tag_vld[LAST-1:0], w_accept};
      r_tag_id[0] <= w_accept ? w_grant_id : '0;
      for (int i = 1; i < ADD_LATENCY; i++) r_tag_id[i] <= r_tag_id[i-1];

      r_rsp_valid <= add_result_valid;
      if (add_result_valid) begin
        r_rsp_data <= add_result;
        // An untagged result is still returned, attributed to requester 0.
        r_rsp_id   <= w_tag_last_vld ? w_tag_last_id : '0;
      end

      // A fresh mismatch wins over a simultaneous clear.
      if (w_tag_last_vld != add_result_valid) r_err <= 1'b1;
      else if (err_clr)                       r_err <= 1'b0;
    end
  end

  assign add_valid = r_add_valid;
  assign add_data1 = r_add_data1;
  assign add_data2 = r_add_data2;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign err       = r_err;
  assign busy      = r_add_valid | (|r_tag_vld) | r_rsp_valid;

endmodule

// File: tb/tb_fp32_add_arbiter.sv
// Directed bench for fp32_add_arbiter with a behavioural adder and a response scoreboard.
// Stimulus pushes expected {id, sum, cycle}; the monitor pops on every rsp_valid.
module tb_fp32_add_arbiter;

  localparam int NUM_REQ     = 4;
  localparam int ADD_LATENCY = 6;
  localparam int ID_W        = 2;

  logic                  s_clk = 1'b0;
  logic                  s_rst_n;
  logic                  en;
  logic [NUM_REQ-1:0]    req_valid;
  logic [32*NUM_REQ-1:0] req_data1;
  logic [32*NUM_REQ-1:0] req_data2;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  add_valid;
  logic [31:0]           add_data1;
  logic [31:0]           add_data2;
  logic                  add_result_valid;
  logic [31:0]           add_result;
  logic                  rsp_valid;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           rsp_data;
  logic                  busy;
  logic                  err;
  logic                  err_clr;

  fp32_add_arbiter #(.NUM_REQ(NUM_REQ), .ADD_LATENCY(ADD_LATENCY)) dut (
    .s_clk(s_clk), .s_rst_n(s_rst_n), .en(en),
    .req_valid(req_valid), .req_data1(req_data1), .req_data2(req_data2),
    .req_ready(req_ready),
    .add_valid(add_valid), .add_data1(add_data1), .add_data2(add_data2),
    .add_result_valid(add_result_valid), .add_result(add_result),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .busy(busy), .err(err), .err_clr(err_clr)
  );

  always #5 s_clk = ~s_clk;

  int unsigned cyc = 0;
  always @(posedge s_clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Hand-computed FP32 sums for every operand pair the bench issues.
  function automatic logic [31:0] fp_sum(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      64'h3F800000_40000000: return 32'h40400000;  // 1 + 2 = 3
      64'h40400000_3F800000: return 32'h40800000;  // 3 + 1 = 4
      64'h40800000_40800000: return 32'h41000000;  // 4 + 4 = 8
      64'h41200000_3F800000: return 32'h41300000;  // 10 + 1 = 11
      64'h3F000000_3F000000: return 32'h3F800000;  // 0.5 + 0.5 = 1
      64'hC0000000_40A00000: return 32'h40400000;  // -2 + 5 = 3
      64'h40A00000_40A00000: return 32'h41200000;  // 5 + 5 = 10
      64'h3FC00000_3FC00000: return 32'h40400000;  // 1.5 + 1.5 = 3
      default:               return a ^ b;
    endcase
  endfunction

  // Behavioural adder: result valid ADD_LATENCY-1 cycles after add_valid is seen high.
  logic [ADD_LATENCY-2:0] m_vld;
  logic [31:0]            m_sum [ADD_LATENCY-1];
  logic                   inj_vld;
  logic [31:0]            inj_data;

  always @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      m_vld <= '0;
    end else begin
      m_vld    <= {m_vld[ADD_LATENCY-3:0], add_valid};
      m_sum[0] <= fp_sum(add_data1, add_data2);
      for (int i = 1; i < ADD_LATENCY - 1; i++) m_sum[i] <= m_sum[i-1];
    end
  end

  assign add_result_valid = m_vld[ADD_LATENCY-2] | inj_vld;
  assign add_result       = inj_vld ? inj_data : m_sum[ADD_LATENCY-2];

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [31:0]     data;
    logic [31:0]     cyc;
  } exp_t;

  exp_t        sb [$];
  exp_t        mon_e;
  logic [31:0] exp_s [NUM_REQ];

  always @(negedge s_clk) begin
    if (s_rst_n && rsp_valid) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("rsp_id",    32'(rsp_id), 32'(mon_e.id));
        check("rsp_data",  rsp_data,    mon_e.data);
        check("rsp_cycle", cyc,         mon_e.cyc);
      end
    end
  end

  task automatic load_set(input bit set_b);
    if (!set_b) begin
      req_data1 = {32'h41200000, 32'h40800000, 32'h40400000, 32'h3F800000};
      req_data2 = {32'h3F800000, 32'h40800000, 32'h3F800000, 32'h40000000};
      exp_s     = '{32'h40400000, 32'h40800000, 32'h41000000, 32'h41300000};
    end else begin
      req_data1 = {32'h3FC00000, 32'h40A00000, 32'hC0000000, 32'h3F000000};
      req_data2 = {32'h3FC00000, 32'h40A00000, 32'h40A00000, 32'h3F000000};
      exp_s     = '{32'h3F800000, 32'h40400000, 32'h41200000, 32'h40400000};
    end
  endtask

  // One cycle of requests: checks the grant and books the expected response.
  task automatic step(input logic e, input logic [NUM_REQ-1:0] vld, input logic [NUM_REQ-1:0] exp_rdy);
    en        = e;
    req_valid = vld;
    @(negedge s_clk);
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    for (int i = 0; i < NUM_REQ; i++)
      if (exp_rdy[i]) sb.push_back('{id: ID_W'(i), data: exp_s[i], cyc: cyc + 7});
    @(posedge s_clk); #1;
    req_valid = '0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_add_valid"}, 32'(add_valid), 32'd0);
    check({tag, "_add_data1"}, add_data1,      32'd0);
    check({tag, "_add_data2"}, add_data2,      32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_id"},    32'(rsp_id),    32'd0);
    check({tag, "_rsp_data"},  rsp_data,       32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_err"},       32'(err),       32'd0);
  endtask

  task automatic do_reset(input string tag);
    en        = 1'b1;
    req_valid = '1;
    s_rst_n   = 1'b0;
    #1;
    check_zero_outputs(tag);
    sb.delete();
    repeat (2) @(posedge s_clk);
    #1;
    s_rst_n   = 1'b1;
    en        = 1'b0;
    req_valid = '0;
    @(posedge s_clk); #1;
  endtask

  task automatic wait_idle(input string tag);
    for (int n = 0; n < 30 && sb.size() != 0; n++) begin
      @(posedge s_clk); #1;
    end
    check({tag, "_drained"}, 32'(sb.size()), 32'd0);
    @(negedge s_clk);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    @(posedge s_clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    s_rst_n  = 1'b0;
    en       = 1'b0;
    req_valid = '0;
    inj_vld  = 1'b0;
    inj_data = '0;
    err_clr  = 1'b0;
    load_set(1'b0);

    do_reset("rst0");

    // Single operation: 1.0 + 2.0 from requester 0.
    step(1'b1, 4'b0001, 4'b0001);
    @(negedge s_clk);
    check("single_add_valid", 32'(add_valid), 32'd1);
    check("single_add_data1", add_data1, 32'h3F800000);
    check("single_add_data2", add_data2, 32'h40000000);
    @(negedge s_clk);
    check("single_add_valid_drop", 32'(add_valid), 32'd0);
    check("single_add_data1_hold", add_data1, 32'h3F800000);
    @(posedge s_clk); #1;
    wait_idle("single");

    // Fairness from a freshly reset pointer.
    do_reset("rst1");
    for (int k = 0; k < 8; k++) step(1'b1, 4'b1111, 4'b0001 << (k % 4));
    wait_idle("fair");
    check("fair_err", 32'(err), 32'd0);

    // Pointer wrap: grant 2 moves the pointer to 3.
    step(1'b1, 4'b0100, 4'b0100);
    step(1'b1, 4'b1001, 4'b1000);
    step(1'b1, 4'b1001, 4'b0001);
    wait_idle("wrap");

    // Drain: three accepts, then en low with requests still pending.
    load_set(1'b1);
    step(1'b1, 4'b1111, 4'b0010);
    step(1'b1, 4'b1111, 4'b0100);
    step(1'b1, 4'b1111, 4'b1000);
    for (int k = 0; k < 4; k++) step(1'b0, 4'b1111, 4'b0000);
    seen = 0;
    for (int n = 0; n < 20 && seen < 3; n++) begin
      @(negedge s_clk);
      if (rsp_valid) begin
        seen++;
        if (seen == 3) check("drain_busy_last_rsp", 32'(busy), 32'd1);
      end
    end
    check("drain_rsp_count", 32'(seen), 32'd3);
    @(negedge s_clk);
    check("drain_busy_fall", 32'(busy), 32'd0);
    @(posedge s_clk); #1;
    wait_idle("drain");

    // Untagged result sets err; clear racing a new mismatch keeps it set.
    inj_vld  = 1'b1;
    inj_data = 32'hDEADBEEF;
    sb.push_back('{id: '0, data: 32'hDEADBEEF, cyc: cyc + 1});
    @(posedge s_clk); #1;
    inj_vld = 1'b0;
    @(negedge s_clk);
    check("err_set", 32'(err), 32'd1);
    @(posedge s_clk); #1;
    @(negedge s_clk);
    check("err_held", 32'(err), 32'd1);
    @(posedge s_clk); #1;
    err_clr  = 1'b1;
    inj_vld  = 1'b1;
    inj_data = 32'h0BADF00D;
    sb.push_back('{id: '0, data: 32'h0BADF00D, cyc: cyc + 1});
    @(posedge s_clk); #1;
    inj_vld = 1'b0;
    @(negedge s_clk);
    check("err_clr_vs_mismatch", 32'(err), 32'd1);
    @(posedge s_clk); #1;
    err_clr = 1'b0;
    @(negedge s_clk);
    check("err_cleared", 32'(err), 32'd0);
    @(posedge s_clk); #1;
    wait_idle("err");

    // Reset three cycles after an accept discards the in-flight operation.
    load_set(1'b0);
    step(1'b1, 4'b0001, 4'b0001);
    en = 1'b0;
    repeat (2) begin
      @(posedge s_clk); #1;
    end
    check("midrst_busy_before", 32'(busy), 32'd1);
    do_reset("midrst");
    repeat (12) begin
      @(posedge s_clk); #1;
    end
    check("midrst_err", 32'(err), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
